// File: rtl/universal_shift_reg.sv
// ---------------------------------------------------------------------------
// universal_shift_reg
//
// Single-cycle universal shift register: hold, parallel load, logical
// shift left/right with serial fill, rotate left/right, arithmetic shift
// right and synchronous clear, all by a variable distance.
//
// Parameters
//   WIDTH        register width in bits (2..64)
//   RESET_VALUE  value forced into q while reset is high
//
// Ports
//   clk    in   1      rising-edge clock
//   reset  in   1      asynchronous, active-high reset
//   en     in   1      operation enable; 0 holds q, sout and zero
//   mode   in   3      000 hold, 001 load, 010 shl, 011 shr,
//                      100 rotl, 101 rotr, 110 sra, 111 clear
//   d      in   WIDTH  parallel load data
//   amt    in   AMT_W  shift/rotate distance (taken modulo WIDTH)
//   sin    in   1      serial fill bit for logical shifts
//   q      out  WIDTH  register contents
//   sout   out  1      last bit shifted/rotated out
//   zero   out  1      registered flag, 1 when q == 0
// ---------------------------------------------------------------------------
module universal_shift_reg #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    localparam int              AMT_W       = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic [AMT_W-1:0] amt,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             zero
);

    typedef enum logic [2:0] {
        M_HOLD = 3'b000,
        M_LOAD = 3'b001,
        M_SHL  = 3'b010,
        M_SHR  = 3'b011,
        M_ROTL = 3'b100,
        M_ROTR = 3'b101,
        M_SRA  = 3'b110,
        M_CLR  = 3'b111
    } mode_e;

    // Out-of-range distances (only possible for non-power-of-2 WIDTH)
    // wrap around rather than over-shifting.
    function automatic logic [AMT_W-1:0] amt_mod(input logic [AMT_W-1:0] a);
        return AMT_W'(int'(a) % WIDTH);
    endfunction

    logic [WIDTH-1:0] r_q;
    logic             r_sout;
    logic             r_zero;

    logic [AMT_W-1:0] w_amt;
    logic             w_amt_nz;
    logic [WIDTH-1:0] w_shl;
    logic [WIDTH-1:0] w_shr;
    logic [WIDTH-1:0] w_sra;
    logic [WIDTH-1:0] w_rotl;
    logic [WIDTH-1:0] w_rotr;
    logic             w_out_l;
    logic             w_out_r;
    logic [WIDTH-1:0] w_q_nxt;
    logic             w_sout_nxt;

    always_comb begin
        w_amt    = amt_mod(amt);
        w_amt_nz = (w_amt != '0);

        // Each operation shifts a double-width word whose spare half holds
        // the fill pattern; the wanted half is then extracted.
        w_shl  = WIDTH'(({r_q, {WIDTH{sin}}} << w_amt) >> WIDTH);
        w_shr  = WIDTH'({{WIDTH{sin}}, r_q} >> w_amt);
        w_sra  = WIDTH'({{WIDTH{r_q[WIDTH-1]}}, r_q} >> w_amt);
        w_rotl = WIDTH'(({r_q, r_q} << w_amt) >> WIDTH);
        w_rotr = WIDTH'({r_q, r_q} >> w_amt);

        // Last bit to leave: shifting by one less than the distance parks it
        // at the exit end (MSB for left moves, LSB for right moves).
        w_out_l = 1'((r_q << (w_amt - AMT_W'(1))) >> (WIDTH - 1));
        w_out_r = 1'(r_q >> (w_amt - AMT_W'(1)));

        w_q_nxt    = r_q;
        w_sout_nxt = r_sout;
        case (mode)
            M_HOLD: w_q_nxt = r_q;
            M_LOAD: w_q_nxt = d;
            M_SHL: begin
                w_q_nxt = w_shl;
                if (w_amt_nz) w_sout_nxt = w_out_l;
            end
            M_SHR: begin
                w_q_nxt = w_shr;
                if (w_amt_nz) w_sout_nxt = w_out_r;
            end
            M_ROTL: begin
                w_q_nxt = w_rotl;
                if (w_amt_nz) w_sout_nxt = w_out_l;
            end
            M_ROTR: begin
                w_q_nxt = w_rotr;
                if (w_amt_nz) w_sout_nxt = w_out_r;
            end
            M_SRA: begin
                w_q_nxt = w_sra;
                if (w_amt_nz) w_sout_nxt = w_out_r;
            end
            M_CLR:   w_q_nxt = '0;
            default: w_q_nxt = r_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q    <= RESET_VALUE;
            r_sout <= 1'b0;
            r_zero <= (RESET_VALUE == '0);
        end else if (en) begin
            r_q    <= w_q_nxt;
            r_sout <= w_sout_nxt;
            r_zero <= (w_q_nxt == '0);
        end
    end

    assign q    = r_q;
    assign sout = r_sout;
    assign zero = r_zero;

endmodule

// File: tb/tb_universal_shift_reg.sv
module tb_universal_shift_reg;

    logic       clk;
    logic       reset;
    logic       en;
    logic [2:0] mode;
    logic [7:0] d;
    logic [2:0] amt;
    logic       sin;
    logic [7:0] q;
    logic       sout;
    logic       zero;

    // Second instance with a non-power-of-2 width to exercise amt wrap.
    logic       en6;
    logic [2:0] mode6;
    logic [5:0] d6;
    logic [2:0] amt6;
    logic       sin6;
    logic [5:0] q6;
    logic       sout6;
    logic       zero6;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state for the random phase.
    logic [7:0] m_q;
    logic       m_sout;
    logic       m_zero;

    universal_shift_reg #(.WIDTH(8), .RESET_VALUE(8'hA5)) u_dut (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .d(d), .amt(amt),
        .sin(sin), .q(q), .sout(sout), .zero(zero)
    );

    universal_shift_reg #(.WIDTH(6), .RESET_VALUE(6'h00)) u_dut6 (
        .clk(clk), .reset(reset), .en(en6), .mode(mode6), .d(d6), .amt(amt6),
        .sin(sin6), .q(q6), .sout(sout6), .zero(zero6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [2:0] m, input logic [7:0] dv, input logic [2:0] a, input logic s);
        en = 1'b1; mode = m; d = dv; amt = a; sin = s;
        tick();
    endtask

    task automatic op6(input logic [2:0] m, input logic [5:0] dv, input logic [2:0] a, input logic s);
        en6 = 1'b1; mode6 = m; d6 = dv; amt6 = a; sin6 = s;
        tick();
    endtask

    task automatic model_step(input logic e, input logic [2:0] m, input logic [7:0] dv,
                              input logic [2:0] a3, input logic s);
        logic [7:0] nq;
        logic       ns;
        int         a;
        a  = int'(a3);
        nq = m_q;
        ns = m_sout;
        case (m)
            3'd1: nq = dv;
            3'd2: begin
                for (int i = 0; i < 8; i++)
                    if (i >= a) nq[i] = m_q[3'(i - a)]; else nq[i] = s;
                if (a > 0) ns = m_q[3'(8 - a)];
            end
            3'd3: begin
                for (int i = 0; i < 8; i++)
                    if (i + a < 8) nq[i] = m_q[3'(i + a)]; else nq[i] = s;
                if (a > 0) ns = m_q[3'(a - 1)];
            end
            3'd4: begin
                for (int i = 0; i < 8; i++) nq[i] = m_q[3'(i - a)];
                if (a > 0) ns = m_q[3'(8 - a)];
            end
            3'd5: begin
                for (int i = 0; i < 8; i++) nq[i] = m_q[3'(i + a)];
                if (a > 0) ns = m_q[3'(a - 1)];
            end
            3'd6: begin
                for (int i = 0; i < 8; i++)
                    if (i + a < 8) nq[i] = m_q[3'(i + a)]; else nq[i] = m_q[7];
                if (a > 0) ns = m_q[3'(a - 1)];
            end
            3'd7: nq = 8'h00;
            default: nq = m_q;
        endcase
        if (e) begin
            m_q    = nq;
            m_sout = ns;
            m_zero = (nq == 8'h00);
        end
    endtask

    initial begin
        reset = 1'b0;
        en = 1'b1; mode = 3'b001; d = 8'h3C; amt = 3'd0; sin = 1'b0;
        en6 = 1'b0; mode6 = 3'b000; d6 = 6'h00; amt6 = 3'd0; sin6 = 1'b0;

        // Load before any reset, then hit reset mid-cycle at 13 ns.
        tick();                                   // t = 6
        check_eq("pre_load_q", q, 8'h3C);
        check_eq("pre_load_zero", zero, 1'b0);
        #7;                                       // t = 13
        d = 8'hFF;
        reset = 1'b1;
        #1;
        check_eq("rst_async_q", q, 8'hA5);
        check_eq("rst_async_sout", sout, 1'b0);
        check_eq("rst_async_zero", zero, 1'b0);
        check_eq("rst6_zero", zero6, 1'b1);
        tick();                                   // edge at 15 with en=1 load
        check_eq("rst_override_q", q, 8'hA5);
        #2 reset = 1'b0; en = 1'b0;
        tick();
        check_eq("post_rst_en0_q", q, 8'hA5);

        // Load / logical shifts
        op(3'b001, 8'h81, 3'd0, 1'b0);
        check_eq("load_q", q, 8'h81);
        op(3'b010, 8'h00, 3'd1, 1'b0);
        check_eq("shl1_q", q, 8'h02);
        check_eq("shl1_sout", sout, 1'b1);
        op(3'b011, 8'h00, 3'd3, 1'b1);
        check_eq("shr3_q", q, 8'hE0);
        check_eq("shr3_sout", sout, 1'b0);

        // Rotate / arithmetic
        op(3'b001, 8'h96, 3'd0, 1'b0);
        op(3'b100, 8'h00, 3'd4, 1'b0);
        check_eq("rotl4_q", q, 8'h69);
        check_eq("rotl4_sout", sout, 1'b1);
        op(3'b001, 8'h96, 3'd0, 1'b0);
        op(3'b110, 8'h00, 3'd2, 1'b0);
        check_eq("sra2_q", q, 8'hE5);
        check_eq("sra2_sout", sout, 1'b1);
        op(3'b101, 8'h00, 3'd3, 1'b0);            // E5 rotr 3 -> BC, out q[2]=1
        check_eq("rotr3_q", q, 8'hBC);

        // Hold / clear / zero flag
        en = 1'b0; mode = 3'b111;
        tick();
        check_eq("hold_clr_q", q, 8'hBC);
        check_eq("hold_clr_zero", zero, 1'b0);
        op(3'b111, 8'h00, 3'd0, 1'b0);
        check_eq("clr_q", q, 8'h00);
        check_eq("clr_zero", zero, 1'b1);
        op(3'b001, 8'h01, 3'd0, 1'b0);
        check_eq("load01_zero", zero, 1'b0);

        // amt = 0 leaves q and sout alone
        op(3'b101, 8'h00, 3'd1, 1'b0);            // 01 rotr 1 -> 80, sout=1
        check_eq("rotr1_q", q, 8'h80);
        check_eq("rotr1_sout", sout, 1'b1);
        op(3'b010, 8'h00, 3'd0, 1'b1);
        check_eq("shl0_q", q, 8'h80);
        check_eq("shl0_sout", sout, 1'b1);
        en = 1'b0;

        // WIDTH=6: amt 6/7 wrap to 0/1
        op6(3'b001, 6'h21, 3'd0, 1'b0);
        check_eq("w6_load_q", q6, 6'h21);
        op6(3'b100, 6'h00, 3'd7, 1'b0);
        check_eq("w6_rotl7_q", q6, 6'h03);
        check_eq("w6_rotl7_sout", sout6, 1'b1);
        op6(3'b010, 6'h00, 3'd6, 1'b1);
        check_eq("w6_shl6_q", q6, 6'h03);
        op6(3'b011, 6'h00, 3'd7, 1'b0);
        check_eq("w6_shr7_q", q6, 6'h01);
        en6 = 1'b0;

        // Random sequence against the reference model
        reset = 1'b1;
        #1;
        reset = 1'b0;
        m_q = 8'hA5; m_sout = 1'b0; m_zero = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            en   = ($urandom_range(0, 7) != 0);
            mode = 3'($urandom_range(0, 7));
            d    = 8'($urandom_range(0, 255));
            amt  = 3'($urandom_range(0, 7));
            sin  = 1'($urandom_range(0, 1));
            model_step(en, mode, d, amt, sin);
            tick();
            check_eq("rnd_q", q, m_q);
            check_eq("rnd_sout", sout, m_sout);
            check_eq("rnd_zero", zero, m_zero);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/universal_shift_reg.md
UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, register width in bits; legal range 2..64.
REQ-002 The block SHALL have parameter RESET_VALUE, default 0, WIDTH-bit value loaded into q on reset.
REQ-003 The block SHALL derive localparam AMT_W = clog2(WIDTH), the width of the shift-amount port.
REQ-004 The block SHALL have port: clk  input  1  clock; all state changes on rising edge.
REQ-005 The block SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-006 The block SHALL have port: en  input  1  operation enable; 0 = hold all state.
REQ-007 The block SHALL have port: mode  input  3  operation select (see REQ-012).
REQ-008 The block SHALL have port: d  input  WIDTH  parallel load data.
REQ-009 The block SHALL have port: amt  input  AMT_W  shift/rotate distance, 0..WIDTH-1.
REQ-010 The block SHALL have port: sin  input  1  serial fill bit for logical shifts.
REQ-011 The block SHALL have outputs: q  output  WIDTH  register contents; sout  output  1  last bit shifted out; zero  output  1  registered flag, 1 when q==0.

Function
REQ-012 When en=1 at a rising clk edge, mode SHALL select: 000 hold, 001 load q<=d, 010 shift left logical, 011 shift right logical, 100 rotate left, 101 rotate right, 110 shift right arithmetic, 111 synchronous clear q<=0.
REQ-013 When en=0, q, sout and zero SHALL hold, regardless of mode, d, amt, sin.
REQ-014 All operations SHALL complete in one cycle: new q visible after the same edge that samples mode.
REQ-015 Shift left by amt SHALL move q toward MSB by amt positions, filling the amt vacated LSBs with sin.
REQ-016 Shift right logical by amt SHALL move q toward LSB by amt positions, filling the amt vacated MSBs with sin.
REQ-017 Shift right arithmetic by amt SHALL fill the vacated MSBs with the pre-shift q[WIDTH-1]; sin ignored.
REQ-018 Rotates by amt SHALL be lossless: bits leaving one end re-enter the other end; sin ignored.
REQ-019 For shifts and rotates with amt>0, sout SHALL be the last bit to leave: shl -> old q[WIDTH-amt]; shr/sra -> old q[amt-1]; rotl -> old q[WIDTH-amt]; rotr -> old q[amt-1].
REQ-020 For amt=0 or modes hold/load/clear, q SHALL follow REQ-012 and sout SHALL hold its previous value.
REQ-021 amt values >= WIDTH (non-power-of-2 WIDTH) SHALL be treated as amt modulo WIDTH.
REQ-022 zero SHALL be registered, updating on the same edge as q to reflect the new q value.

Reset
REQ-023 While reset=1, q SHALL equal RESET_VALUE, sout 0, zero (RESET_VALUE==0), independent of clk.
REQ-024 Reset assertion SHALL take effect immediately, including mid-cycle, overriding any en/mode.
REQ-025 On the first rising edge after reset deasserts, normal operation per REQ-012 SHALL resume.

Verification
REQ-026 Reset: WIDTH=8, RESET_VALUE=8'hA5, assert reset at 13 ns between edges -> q=A5, sout=0, zero=0 immediately; release -> first edge with en=0 keeps A5.
REQ-027 Load/shift: load d=8'h81; shl amt=1, sin=0 -> q=02, sout=1; shr amt=3, sin=1 -> q=E0, sout=0.
REQ-028 Rotate/arith: q=8'h96; rotl amt=4 -> q=69, sout=1; sra amt=2 on q=8'h96 -> q=E5, sout=1.
REQ-029 Hold/zero: en=0 with mode=111 -> q unchanged; en=1 mode=111 -> q=00, zero=1 same edge; load 01 -> zero=0.
REQ-030 amt=0 shl with sout=1 -> q and sout unchanged; random mode/amt/d/sin sequence of 1000 cycles matches a reference model cycle-for-cycle.
